// File: rtl/fifo_access_scheduler.sv
// Access scheduler for a single FIFO shared by NUM_REQ round-robin writers and one reader.
// Tracks committed occupancy itself and drains the FIFO on a flush request.
module fifo_access_scheduler #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int NUM_REQ = 4,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       wr_req,
    input  logic [NUM_REQ*WIDTH-1:0] wr_data,
    output logic [NUM_REQ-1:0]       wr_gnt,
    input  logic                     rd_req,
    output logic                     rd_gnt,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    input  logic                     flush,
    output logic                     flush_done,
    output logic                     fifo_push,
    output logic                     fifo_pop,
    output logic [WIDTH-1:0]         fifo_in,
    input  logic [WIDTH-1:0]         fifo_out,
    input  logic                     fifo_empty,
    input  logic                     fifo_full,
    output logic [CW-1:0]            occupancy,
    output logic                     err
);

    localparam int          PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NR      = NUM_REQ;
    localparam logic [CW-1:0] OCC_MAX = CW'(DEPTH);

    typedef enum logic {S_IDLE, S_FLUSH} state_t;
    typedef enum logic {OP_POP, OP_PUSH} op_t;

    state_t               state_q, state_d;
    op_t                  last_op_q, last_op_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                 fifo_push_q, fifo_push_d;
    logic                 fifo_pop_q, fifo_pop_d;
    logic [WIDTH-1:0]     fifo_in_q, fifo_in_d;
    logic [NUM_REQ-1:0]   wr_gnt_q, wr_gnt_d;
    logic                 rd_gnt_q, rd_gnt_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0]     rd_data_q, rd_data_d;
    logic                 flush_done_q, flush_done_d;
    logic [CW-1:0]        occ_q, occ_d;
    logic                 err_q, err_d;
    logic                 full_div_q, empty_div_q;

    logic [NUM_REQ-1:0]   wr_elig;
    logic                 rd_elig;
    logic                 wr_any;
    logic [PW-1:0]        wr_sel;
    logic [PW-1:0]        idx;
    logic [PW-1:0]        rr_next;
    logic [WIDTH-1:0]     wr_sel_data;
    logic                 full_div, empty_div;

    // The requester granted last cycle is masked so it can drop its request in time.
    always_comb begin
        wr_elig     = (occ_q != OCC_MAX) ? (wr_req & ~wr_gnt_q) : '0;
        rd_elig     = rd_req && !rd_gnt_q && (occ_q != '0);
        wr_any      = 1'b0;
        wr_sel      = '0;
        idx         = '0;
        wr_sel_data = '0;
        for (int unsigned off = 0; off < NR; off++) begin
            idx = PW'((32'(rr_ptr_q) + off) % NR);
            if (!wr_any && wr_elig[idx]) begin
                wr_any = 1'b1;
                wr_sel = idx;
            end
        end
        for (int unsigned i = 0; i < NR; i++) begin
            if (wr_sel == PW'(i)) begin
                wr_sel_data = wr_data[i*WIDTH +: WIDTH];
            end
        end
        rr_next = (wr_sel == PW'(NR - 1)) ? '0 : wr_sel + 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        last_op_d    = last_op_q;
        fifo_push_d  = 1'b0;
        fifo_pop_d   = 1'b0;
        fifo_in_d    = fifo_in_q;
        wr_gnt_d     = '0;
        rd_gnt_d     = 1'b0;
        rd_valid_d   = rd_gnt_q;
        rd_data_d    = rd_gnt_q ? fifo_out : rd_data_q;
        flush_done_d = 1'b0;
        occ_d        = occ_q;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    // The first drain pop is issued on the flush edge itself.
                    if (occ_q == '0) begin
                        flush_done_d = 1'b1;
                    end else begin
                        fifo_pop_d = 1'b1;
                        occ_d      = occ_q - 1'b1;
                        last_op_d  = OP_POP;
                        state_d    = S_FLUSH;
                    end
                end else if (wr_any && (!rd_elig || last_op_q == OP_POP)) begin
                    fifo_push_d      = 1'b1;
                    wr_gnt_d[wr_sel] = 1'b1;
                    fifo_in_d        = wr_sel_data;
                    occ_d            = occ_q + 1'b1;
                    last_op_d        = OP_PUSH;
                    rr_ptr_d         = rr_next;
                end else if (rd_elig) begin
                    fifo_pop_d = 1'b1;
                    rd_gnt_d   = 1'b1;
                    occ_d      = occ_q - 1'b1;
                    last_op_d  = OP_POP;
                end
            end
            S_FLUSH: begin
                if (occ_q != '0) begin
                    fifo_pop_d = 1'b1;
                    occ_d      = occ_q - 1'b1;
                    last_op_d  = OP_POP;
                end else begin
                    flush_done_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The FIFO flags lag the committed count by one cycle, so divergence must persist two cycles.
    always_comb begin
        full_div  = (occ_q == OCC_MAX) && !fifo_full;
        empty_div = (occ_q == '0) && !fifo_empty;
        err_d     = err_q
                  | (fifo_push_q & fifo_full)
                  | (fifo_pop_q & fifo_empty)
                  | (full_div & full_div_q)
                  | (empty_div & empty_div_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_op_q    <= OP_POP;
            rr_ptr_q     <= '0;
            fifo_push_q  <= 1'b0;
            fifo_pop_q   <= 1'b0;
            fifo_in_q    <= '0;
            wr_gnt_q     <= '0;
            rd_gnt_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            flush_done_q <= 1'b0;
            occ_q        <= '0;
            err_q        <= 1'b0;
            full_div_q   <= 1'b0;
            empty_div_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_op_q    <= last_op_d;
            rr_ptr_q     <= rr_ptr_d;
            fifo_push_q  <= fifo_push_d;
            fifo_pop_q   <= fifo_pop_d;
            fifo_in_q    <= fifo_in_d;
            wr_gnt_q     <= wr_gnt_d;
            rd_gnt_q     <= rd_gnt_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            flush_done_q <= flush_done_d;
            occ_q        <= occ_d;
            err_q        <= err_d;
            full_div_q   <= full_div;
            empty_div_q  <= empty_div;
        end
    end

    assign wr_gnt     = wr_gnt_q;
    assign rd_gnt     = rd_gnt_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign flush_done = flush_done_q;
    assign fifo_push  = fifo_push_q;
    assign fifo_pop   = fifo_pop_q;
    assign fifo_in    = fifo_in_q;
    assign occupancy  = occ_q;
    assign err        = err_q;

endmodule
